// File: rtl/maxnet_loader_pkg.sv
// Shared types and FP32 field constants for the Maxnet loader.
package maxnet_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;
  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;

  // 0.3 in FP32
  localparam logic [31:0] EPS_RESET_DEFAULT = 32'h3E99_999A;

endpackage

// File: rtl/maxnet_loader_if.sv
// Candidate stream, result stream and Maxnet-side signals of the loader.
interface maxnet_loader_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] eps_data;
  logic        eps_load;
  logic [31:0] num1, num2, num3, num4;
  logic [31:0] epsilon;
  logic        start;
  logic        mx_done;
  logic [31:0] mx_max;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        err_nan;
  logic        err_timeout;

  // Loader side
  modport slave (
    input  in_data, in_valid, eps_data, eps_load, mx_done, mx_max, res_ready,
    output in_ready, num1, num2, num3, num4, epsilon, start,
           res_data, res_valid, busy, err_nan, err_timeout
  );

  // Upstream / downstream / Maxnet side
  modport master (
    output in_data, in_valid, eps_data, eps_load, mx_done, mx_max, res_ready,
    input  in_ready, num1, num2, num3, num4, epsilon, start,
           res_data, res_valid, busy, err_nan, err_timeout
  );
endinterface

// File: rtl/maxnet_loader_sanitize.sv
// FP32 candidate sanitiser: Inf/NaN, negatives, -0 and denormals become +0.
module fp32_sanitize
  import maxnet_pkg::*;
(
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic        is_nan_inf
);

  logic [7:0] w_exp;
  logic       w_zero_it;

  assign w_exp = in[EXP_MSB:EXP_LSB];

  // Classify and zero anything Maxnet must not see
  always_comb begin
    is_nan_inf = (w_exp == EXP_ALL1);
    w_zero_it  = is_nan_inf | in[SIGN_BIT] | (w_exp == 8'h00);
    out        = w_zero_it ? FP_ZERO : in;
  end

endmodule

// File: rtl/maxnet_loader.sv
// Maxnet feeder: buffers four sanitised candidates, launches the core,
// waits for done (with timeout) and hands the winner downstream.
module maxnet_loader
  import maxnet_pkg::*;
#(
  parameter logic [31:0] EPS_RESET      = EPS_RESET_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  maxnet_loader_if.slave   bus
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [3:0][31:0]  r_num;
  logic [31:0]       r_eps;
  logic [TW-1:0]     r_tmr;
  logic              r_start;
  logic              r_res_valid;
  logic [31:0]       r_res_data;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_err_nan;
  logic              r_err_to;

  logic [31:0]       w_san;
  logic              w_nan;
  logic              w_xfer;

  fp32_sanitize u_san (
    .in         (bus.in_data),
    .out        (w_san),
    .is_nan_inf (w_nan)
  );

  assign w_xfer = bus.in_valid & r_in_ready;

  // Loader FSM: all outputs registered, slots only written in COLLECT
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= COLLECT;
      r_cnt       <= 2'd0;
      r_num       <= '0;
      r_eps       <= EPS_RESET;
      r_tmr       <= '0;
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= FP_ZERO;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_err_nan   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (bus.eps_load) r_eps <= bus.eps_data;
          if (w_xfer) begin
            r_num[r_cnt] <= w_san;
            r_cnt        <= r_cnt + 2'd1;
            if (w_nan) r_err_nan <= 1'b1;
            if (r_cnt == 2'd3) begin
              r_state    <= LAUNCH;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          // A done still high from the previous run must drop first
          if (!bus.mx_done) begin
            r_start <= 1'b1;
            r_tmr   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_tmr <= r_tmr + TW'(1);
          if (bus.mx_done) begin
            r_res_data  <= bus.mx_max;
            r_start     <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end else if (r_tmr == TMR_LAST) begin
            r_res_data  <= FP_ZERO;
            r_err_to    <= 1'b1;
            r_start     <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.busy        = r_busy;
  assign bus.num1        = r_num[0];
  assign bus.num2        = r_num[1];
  assign bus.num3        = r_num[2];
  assign bus.num4        = r_num[3];
  assign bus.epsilon     = r_eps;
  assign bus.start       = r_start;
  assign bus.res_data    = r_res_data;
  assign bus.res_valid   = r_res_valid;
  assign bus.err_nan     = r_err_nan;
  assign bus.err_timeout = r_err_to;

endmodule

// File: tb/tb_maxnet_loader.sv
// Directed bench for maxnet_loader with a behavioural Maxnet stub.
module tb_maxnet_loader;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic exp_nan = 1'b0;

  always #5 clk = ~clk;

  maxnet_loader_if bus();

  maxnet_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0][31:0] din;
    logic [3:0][31:0] dexp;
    logic [31:0]      mx;
    logic             nan;
    int               dly;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [3:0][31:0] mk(input logic [31:0] a, b, c, d);
    logic [3:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_nums(input string nm, input logic [3:0][31:0] e);
    chk({nm, "_num1"}, bus.num1, e[0]);
    chk({nm, "_num2"}, bus.num2, e[1]);
    chk({nm, "_num3"}, bus.num3, e[2]);
    chk({nm, "_num4"}, bus.num4, e[3]);
  endtask

  // Four back-to-back transfers, then check the LAUNCH cycle and the start rise
  task automatic send4(input string nm, input logic [3:0][31:0] d);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
      bus.in_data  = d[i];
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    chk({nm, "_launch_start"}, 32'(bus.start), 32'd0);
    chk({nm, "_launch_busy"}, 32'(bus.busy), 32'd1);
    chk({nm, "_launch_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  // In WAIT: dly cycles without done, then done for one cycle, then accept result
  task automatic finish_run(input string nm, input logic [31:0] mx, input int dly);
    for (int k = 0; k < dly; k++) begin
      chk({nm, "_wait_start"}, 32'(bus.start), 32'd1);
      chk({nm, "_wait_res_valid"}, 32'(bus.res_valid), 32'd0);
      step();
    end
    bus.mx_done = 1'b1;
    bus.mx_max  = mx;
    step();
    bus.mx_done = 1'b0;
    chk({nm, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    chk({nm, "_res_data"}, bus.res_data, mx);
    chk({nm, "_start_low"}, 32'(bus.start), 32'd0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk({nm, "_res_valid_clr"}, 32'(bus.res_valid), 32'd0);
    chk({nm, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    chk({nm, "_busy_clr"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cnt;

    vecs[0].din  = mk(32'h3ECCCCCD, 32'h3FCCCCCD, 32'h3FD9999A, 32'h3FA66666);
    vecs[0].dexp = mk(32'h3ECCCCCD, 32'h3FCCCCCD, 32'h3FD9999A, 32'h3FA66666);
    vecs[0].mx   = 32'h3F19999A; vecs[0].nan = 1'b0; vecs[0].dly = 9;
    vecs[1].din  = mk(32'hBF800000, 32'h00000001, 32'h7FC00000, 32'h3F800000);
    vecs[1].dexp = mk(32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000);
    vecs[1].mx   = 32'h3F800000; vecs[1].nan = 1'b1; vecs[1].dly = 3;
    vecs[2].din  = mk(32'h80000000, 32'h7F800000, 32'h007FFFFF, 32'h00800000);
    vecs[2].dexp = mk(32'h00000000, 32'h00000000, 32'h00000000, 32'h00800000);
    vecs[2].mx   = 32'h00800000; vecs[2].nan = 1'b1; vecs[2].dly = 0;
    vecs[3].din  = mk(32'h7F7FFFFF, 32'hFF800000, 32'h3F800001, 32'h40490FDB);
    vecs[3].dexp = mk(32'h7F7FFFFF, 32'h00000000, 32'h3F800001, 32'h40490FDB);
    vecs[3].mx   = 32'h7F7FFFFF; vecs[3].nan = 1'b1; vecs[3].dly = 1;

    rst = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.eps_data = '0; bus.eps_load = 1'b0;
    bus.mx_done = 1'b0; bus.mx_max = '0; bus.res_ready = 1'b0;
    step(); step();

    // Reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'h0);
    chk("rst_epsilon", bus.epsilon, 32'h3E99999A);
    chk("rst_err_nan", 32'(bus.err_nan), 32'd0);
    chk("rst_err_to", 32'(bus.err_timeout), 32'd0);
    chk_nums("rst", mk(32'h0, 32'h0, 32'h0, 32'h0));
    rst = 1'b1;
    step();

    // Table of complete runs
    for (int v = 0; v < 4; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      send4(nm, vecs[v].din);
      exp_nan = exp_nan | vecs[v].nan;
      step();
      chk({nm, "_start_rise"}, 32'(bus.start), 32'd1);
      chk_nums(nm, vecs[v].dexp);
      chk({nm, "_epsilon"}, bus.epsilon, 32'h3E99999A);
      chk({nm, "_err_nan"}, 32'(bus.err_nan), 32'(exp_nan));
      finish_run(nm, vecs[v].mx, vecs[v].dly);
    end

    // Timeout: done never comes
    send4("to", mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000));
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.start) cnt++;
      if (bus.res_valid) break;
    end
    chk("to_start_cycles", 32'(cnt), 32'd16);
    chk("to_res_valid", 32'(bus.res_valid), 32'd1);
    chk("to_res_data", bus.res_data, 32'h0);
    chk("to_err_timeout", 32'(bus.err_timeout), 32'd1);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("to_back_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-pressure on the result with candidates offered during HOLD
    send4("bp", mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000));
    step(); step(); step();
    bus.mx_done = 1'b1; bus.mx_max = 32'h40800000;
    step();
    bus.mx_done = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h3F000000;
    for (int k = 0; k < 5; k++) begin
      chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_res_data", bus.res_data, 32'h40800000);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    chk("bp_num1_kept", bus.num1, 32'h3F800000);
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp_res_valid_clr", 32'(bus.res_valid), 32'd0);

    // Epsilon load ignored in WAIT, then stale done held into next run
    send4("eps", mk(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000));
    step();
    bus.eps_data = 32'h3DCCCCCD; bus.eps_load = 1'b1;
    step();
    bus.eps_load = 1'b0;
    chk("eps_wait_ignored", bus.epsilon, 32'h3E99999A);
    bus.mx_done = 1'b1; bus.mx_max = 32'h3F000000;
    step();
    chk("eps_res_valid", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    bus.eps_load = 1'b1;
    step();
    bus.eps_load = 1'b0;
    chk("eps_collect_load", bus.epsilon, 32'h3DCCCCCD);
    send4("stale", mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stale_start_low", 32'(bus.start), 32'd0);
      chk("stale_busy", 32'(bus.busy), 32'd1);
    end
    bus.mx_done = 1'b0;
    step();
    chk("stale_start_rise", 32'(bus.start), 32'd1);
    chk("stale_epsilon", bus.epsilon, 32'h3DCCCCCD);
    finish_run("stale", 32'h40000000, 2);

    // Reset in the middle of WAIT, then a fresh run
    send4("mid", mk(32'h7FC00000, 32'h3F800000, 32'h3F800000, 32'h3F800000));
    step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_start", 32'(bus.start), 32'd0);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_err_nan", 32'(bus.err_nan), 32'd0);
    chk("mid_err_to", 32'(bus.err_timeout), 32'd0);
    chk("mid_epsilon", bus.epsilon, 32'h3E99999A);
    chk_nums("mid", mk(32'h0, 32'h0, 32'h0, 32'h0));
    send4("fresh", mk(32'h3E000000, 32'h3E800000, 32'h3F000000, 32'h3F400000));
    step();
    chk("fresh_start_rise", 32'(bus.start), 32'd1);
    chk_nums("fresh", mk(32'h3E000000, 32'h3E800000, 32'h3F000000, 32'h3F400000));
    finish_run("fresh", 32'h3F400000, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxnet_loader.md
Name: maxnet_loader

Overview:
Upstream feeder and result capture for the Maxnet core. Accepts FP32 candidates one per handshake over a valid/ready stream, sanitises them, and buffers four. It then drives num1..num4 and epsilon into Maxnet, pulses the launch, waits for done, and returns the winning value downstream over a second valid/ready port. A timeout guards against a hung core.

Parameters:
EPS_RESET, 32'h3E99999A (0.3), epsilon value after reset
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort; counter width = clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on clk edge)
in_data  in  32  FP32 candidate
in_valid  in  1  candidate valid
in_ready  out  1  loader can accept candidate
eps_data  in  32  new epsilon
eps_load  in  1  load eps_data (honoured only in COLLECT)
num1,num2,num3,num4  out  32 each  sanitised candidates to Maxnet, in arrival order
epsilon  out  32  epsilon to Maxnet
start  out  1  Maxnet start
mx_done  in  1  Maxnet done
mx_max  in  32  Maxnet max
res_data  out  32  winning value
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
busy  out  1  high in any state other than COLLECT
err_nan  out  1  sticky: an Inf/NaN candidate was seen
err_timeout  out  1  sticky: a run timed out

Behaviour:
- Reset values:
  - num1..num4, res_data = 0; epsilon = EPS_RESET.
  - start, res_valid, busy, err_nan, err_timeout = 0; in_ready = 1.
  - State = COLLECT; count = 0.
- Reset mid-run returns to COLLECT immediately and discards the buffer.
- Sanitise rules, combinational, applied before storing:
  - exp = 8'hFF → store 32'h0 and set err_nan.
  - sign = 1, or exp = 0 (negative, -0, denormal) → store 32'h0.
  - Otherwise store unchanged.
- COLLECT:
  - in_ready = 1. Each cycle with in_valid & in_ready stores into slot[count] and increments count (2-bit).
  - eps_load → epsilon <= eps_data. If eps_load coincides with the 4th transfer, epsilon is still updated before LAUNCH.
  - After the 4th transfer: count wraps to 0 and the next state is LAUNCH.
- LAUNCH:
  - in_ready = 0.
  - Stay while mx_done = 1, so a stale done from the previous run is never accepted.
  - When mx_done = 0: start <= 1, clear timer, go to WAIT.
- WAIT:
  - start held at 1 and the timer increments each cycle.
  - On the first cycle with mx_done = 1: res_data <= mx_max, start <= 0, res_valid <= 1, go to HOLD.
  - Else if timer == TIMEOUT_CYCLES-1: res_data <= 0, err_timeout <= 1, start <= 0, res_valid <= 1, go to HOLD.
  - If done and timeout coincide, done wins.
- HOLD:
  - res_valid stays 1 and res_data stays stable until res_ready.
  - On res_valid & res_ready: res_valid <= 0, go to COLLECT. in_ready rises the cycle after.
  - No new candidates are accepted in HOLD.
- Latency:
  - From the 4th input transfer to the start rise: 2 cycles (LAUNCH registered), provided mx_done = 0.
  - From mx_done high to res_valid high: 1 cycle.
- num1..num4 and epsilon are stable from LAUNCH until re-entry to COLLECT. Slots are overwritten only in COLLECT.
- err_nan and err_timeout clear only on reset.

Decomposition:
- Shared package maxnet_pkg:
  - state enum {COLLECT, LAUNCH, WAIT, HOLD}.
  - FP32 field constants: SIGN_BIT = 31, EXP_MSB = 30, EXP_LSB = 23, EXP_ALL1 = 8'hFF.
  - FP_ZERO = 32'h0.
  - EPS_RESET default.
- One natural sub-module, fp32_sanitize: combinational, input in[31:0]; outputs out[31:0] and is_nan_inf.

Test Plan:
- Normal run: send 3ECCCCCD, 3FCCCCCD, 3FD9999A, 3FA66666 back-to-back; Maxnet stub raises done after 10 cycles with mx_max = 3F19999A → num1..num4 match inputs, epsilon = 3E99999A, start high 2 cycles after the 4th transfer, res_data = 3F19999A with res_valid 1 cycle after done.
- Sanitise: inputs BF800000, 00000001, 7FC00000, 3F800000 → num1..num4 = 0, 0, 0, 3F800000; err_nan = 1.
- Timeout: stub never asserts done, TIMEOUT_CYCLES = 16 → start high for exactly 16 cycles; res_data = 0; res_valid = 1; err_timeout = 1.
- Back-pressure: hold res_ready = 0 for 5 cycles, in_valid = 1 throughout → res_data stable, in_ready = 0 throughout; after res_ready, in_ready = 1 the next cycle.
- Stale done and epsilon load: stub keeps done = 1 into the next run → start stays 0 until done falls. eps_load = 3DCCCCCD during WAIT is ignored; the same value loaded in COLLECT appears on epsilon next cycle.
- Reset mid-WAIT: rst = 0 for 1 cycle → start = 0, busy = 0, count = 0, errors cleared; a fresh 4-input run completes correctly.
